// File: rtl/cell_ingress_writer.sv
// Cell ingress writer: descriptor FIFO, admission, cell SRAM and link writes, enqueue.
// Optional statistics counters are enabled with CELL_INGRESS_STATS_EN.
module cell_ingress_writer #(
  parameter int DATA_W         = 128,
  parameter int BEATS_PER_CELL = 4,
  parameter int PTR_W          = 10,
  parameter int NUM_PORTS      = 4,
  parameter int CNT_W          = 6,
  parameter int DESC_DEPTH     = 4,
  localparam int BW            = $clog2(BEATS_PER_CELL)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PORTS+CNT_W-1:0] desc_din,
  input  logic                    desc_wr,
  output logic                    desc_bp,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    data_wr,
  output logic                    data_bp,
  input  logic [PTR_W-1:0]        fq_ptr,
  input  logic                    fq_empty,
  input  logic [PTR_W:0]          fq_count,
  output logic                    fq_rd,
  output logic                    sram_wr,
  output logic [PTR_W+BW-1:0]     sram_addr,
  output logic [DATA_W-1:0]       sram_din,
  output logic                    link_wr,
  output logic [PTR_W-1:0]        link_addr,
  output logic [PTR_W-1:0]        link_din,
  output logic                    enq_valid,
  input  logic                    enq_ready,
  output logic [PTR_W-1:0]        enq_head,
  output logic [PTR_W-1:0]        enq_tail,
  output logic [NUM_PORTS-1:0]    enq_bitmap,
  output logic [CNT_W-1:0]        enq_cnt,
  output logic                    drop
`ifdef CELL_INGRESS_STATS_EN
  ,
  output logic [31:0]             stat_frames,
  output logic [31:0]             stat_drops,
  output logic [31:0]             stat_cells
`endif
);

  localparam int DW = NUM_PORTS + CNT_W;
  localparam int AW = $clog2(DESC_DEPTH);
  localparam int QW = AW + 1;
  localparam int CW = (PTR_W + 1 > CNT_W) ? PTR_W + 1 : CNT_W;

  typedef enum logic [2:0] {IDLE, ADMIT, WRITE, DROP, ENQ} state_t;

  state_t state, nxt;

  logic [DW-1:0]        fifo_mem [DESC_DEPTH];
  logic [AW-1:0]        wp, rp;
  logic [QW-1:0]        cnt_q;
  logic                 push, pop;

  logic [NUM_PORTS-1:0] f_bitmap;
  logic [CNT_W-1:0]     f_cnt;
  logic [BW-1:0]        beat_idx;
  logic [CNT_W-1:0]     cell_idx;
  logic [PTR_W-1:0]     cur_ptr, head, tail;
  logic [PTR_W-1:0]     wptr;
  logic                 accept, first, last_beat, last_cell, fq_miss;

  assign desc_bp   = (cnt_q == QW'(DESC_DEPTH));
  assign push      = desc_wr && !desc_bp;
  assign accept    = data_wr && !data_bp;
  assign first     = (beat_idx == '0);
  assign last_beat = (beat_idx == BW'(BEATS_PER_CELL - 1));
  assign last_cell = (cell_idx == f_cnt - CNT_W'(1));
  assign fq_miss   = (state == WRITE) && accept && first && fq_empty;
  assign wptr      = first ? fq_ptr : cur_ptr;

  assign enq_head   = head;
  assign enq_tail   = tail;
  assign enq_bitmap = f_bitmap;
  assign enq_cnt    = f_cnt;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wp] <= desc_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + QW'(1);
        2'b01:   cnt_q <= cnt_q - QW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_comb begin
    nxt       = state;
    pop       = 1'b0;
    drop      = 1'b0;
    fq_rd     = 1'b0;
    data_bp   = 1'b1;
    enq_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (cnt_q != '0) begin
          pop = 1'b1;
          nxt = ADMIT;
        end
      end
      ADMIT: begin
        if (f_cnt == '0 || f_bitmap == '0) begin
          drop = 1'b1;
          nxt  = IDLE;
        end else if (CW'(fq_count) >= CW'(f_cnt)) begin
          nxt = WRITE;
        end else begin
          drop = 1'b1;
          nxt  = DROP;
        end
      end
      WRITE: begin
        data_bp = 1'b0;
        if (accept) begin
          // No pointer for a new cell: discard the rest of the frame.
          if (first && fq_empty) begin
            drop = 1'b1;
            nxt  = DROP;
          end else begin
            fq_rd = first;
            if (last_beat && last_cell) nxt = ENQ;
          end
        end
      end
      DROP: begin
        data_bp = 1'b0;
        if (accept && last_beat && last_cell) nxt = IDLE;
      end
      ENQ: begin
        enq_valid = 1'b1;
        if (enq_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      f_bitmap  <= '0;
      f_cnt     <= '0;
      beat_idx  <= '0;
      cell_idx  <= '0;
      cur_ptr   <= '0;
      head      <= '0;
      tail      <= '0;
      sram_wr   <= 1'b0;
      sram_addr <= '0;
      sram_din  <= '0;
      link_wr   <= 1'b0;
      link_addr <= '0;
      link_din  <= '0;
    end else begin
      state   <= nxt;
      sram_wr <= 1'b0;
      link_wr <= 1'b0;
      if (pop) {f_bitmap, f_cnt} <= fifo_mem[rp];
      if (state == ADMIT) begin
        beat_idx <= '0;
        cell_idx <= '0;
      end
      if ((state == WRITE || state == DROP) && accept) begin
        beat_idx <= beat_idx + BW'(1);
        if (last_beat) cell_idx <= cell_idx + CNT_W'(1);
      end
      if (state == WRITE && accept && !fq_miss) begin
        sram_wr   <= 1'b1;
        sram_addr <= {wptr, beat_idx};
        sram_din  <= data_in;
        if (first) begin
          cur_ptr <= fq_ptr;
          tail    <= fq_ptr;
          if (cell_idx == '0) begin
            head <= fq_ptr;
          end else begin
            link_wr   <= 1'b1;
            link_addr <= cur_ptr;
            link_din  <= fq_ptr;
          end
        end
      end
    end
  end

`ifdef CELL_INGRESS_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_frames <= '0;
      stat_drops  <= '0;
      stat_cells  <= '0;
    end else begin
      if (enq_valid && enq_ready && stat_frames != '1)
        stat_frames <= stat_frames + 32'd1;
      if (drop && stat_drops != '1)
        stat_drops <= stat_drops + 32'd1;
      if (fq_rd && stat_cells != '1)
        stat_cells <= stat_cells + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cell_ingress_writer.sv
// Directed testbench for cell_ingress_writer (default build, stats disabled).
// A free-queue model feeds sequential pointers; a negedge monitor logs writes.
module tb_cell_ingress_writer;

  localparam int DATA_W = 128;
  localparam int PTR_W  = 10;
  localparam int NP     = 4;
  localparam int CNT_W  = 6;
  localparam int BW     = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NP+CNT_W-1:0]  desc_din;
  logic                 desc_wr;
  logic                 desc_bp;
  logic [DATA_W-1:0]    data_in;
  logic                 data_wr;
  logic                 data_bp;
  logic [PTR_W-1:0]     fq_ptr;
  logic                 fq_empty;
  logic [PTR_W:0]       fq_count;
  logic                 fq_rd;
  logic                 sram_wr;
  logic [PTR_W+BW-1:0]  sram_addr;
  logic [DATA_W-1:0]    sram_din;
  logic                 link_wr;
  logic [PTR_W-1:0]     link_addr;
  logic [PTR_W-1:0]     link_din;
  logic                 enq_valid;
  logic                 enq_ready;
  logic [PTR_W-1:0]     enq_head;
  logic [PTR_W-1:0]     enq_tail;
  logic [NP-1:0]        enq_bitmap;
  logic [CNT_W-1:0]     enq_cnt;
  logic                 drop;

  int checks = 0;
  int errors = 0;

  cell_ingress_writer dut (
    .clk(clk), .rst(rst),
    .desc_din(desc_din), .desc_wr(desc_wr), .desc_bp(desc_bp),
    .data_in(data_in), .data_wr(data_wr), .data_bp(data_bp),
    .fq_ptr(fq_ptr), .fq_empty(fq_empty), .fq_count(fq_count), .fq_rd(fq_rd),
    .sram_wr(sram_wr), .sram_addr(sram_addr), .sram_din(sram_din),
    .link_wr(link_wr), .link_addr(link_addr), .link_din(link_din),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_head(enq_head), .enq_tail(enq_tail),
    .enq_bitmap(enq_bitmap), .enq_cnt(enq_cnt), .drop(drop)
  );

  always #5 clk = ~clk;

  // Free queue: head advances on every pop
  logic [PTR_W-1:0] fq_base = '0;
  int fq_pops = 0;
  assign fq_ptr = fq_base + PTR_W'(fq_pops);
  always @(posedge clk) if (fq_rd) fq_pops <= fq_pops + 1;

  int sram_n = 0, link_n = 0, drop_n = 0, fqrd_n = 0;
  logic [PTR_W+BW-1:0] sram_a [512];
  logic [DATA_W-1:0]   sram_d [512];
  logic [PTR_W-1:0]    link_a [64];
  logic [PTR_W-1:0]    link_d [64];

  always @(negedge clk) begin
    if (sram_wr && sram_n < 512) begin
      sram_a[sram_n] = sram_addr;
      sram_d[sram_n] = sram_din;
      sram_n++;
    end
    if (link_wr && link_n < 64) begin
      link_a[link_n] = link_addr;
      link_d[link_n] = link_din;
      link_n++;
    end
    if (drop) drop_n++;
    if (fq_rd) fqrd_n++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int p);
    fq_base = PTR_W'(p) - PTR_W'(fq_pops);
  endtask

  task automatic push_desc(input logic [NP-1:0] bm, input logic [CNT_W-1:0] c);
    desc_din = {bm, c};
    desc_wr  = 1'b1;
    tick();
    desc_wr  = 1'b0;
  endtask

  task automatic send_beats(input int n, input int base, output int got);
    int budget;
    got = 0;
    budget = 0;
    while (got < n && budget < 200) begin
      data_wr = 1'b1;
      data_in = DATA_W'(base + got);
      #1;
      if (!data_bp) got++;
      tick();
      budget++;
    end
    data_wr = 1'b0;
  endtask

  task automatic wait_enq(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      if (enq_valid) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic ack_enq;
    enq_ready = 1'b1;
    tick();
    enq_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (desc_bp !== 1'b0) begin errors++; $display("FAIL reset_desc_bp got %0b want 0", desc_bp); end
    checks++; if (data_bp !== 1'b1) begin errors++; $display("FAIL reset_data_bp got %0b want 1", data_bp); end
    checks++; if ({sram_wr, link_wr, fq_rd, enq_valid, drop} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes got %b want 00000", {sram_wr, link_wr, fq_rd, enq_valid, drop});
    end
    checks++; if (sram_addr !== '0 || enq_head !== '0) begin
      errors++; $display("FAIL reset_regs got addr %0d head %0d want 0 0", sram_addr, enq_head);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write;
    int s0, l0, f0, got, bad;
    bit ok;
    s0 = sram_n; l0 = link_n; f0 = fqrd_n;
    set_start(5);
    push_desc(4'b0010, 6'd4);
    send_beats(16, 0, got);
    checks++; if (got != 16) begin errors++; $display("FAIL write_beats got %0d want 16", got); end
    wait_enq(ok);
    checks++; if (!ok) begin errors++; $display("FAIL write_enq_timeout got 0 want 1"); end
    checks++; if (enq_head !== 10'd5 || enq_tail !== 10'd8) begin
      errors++; $display("FAIL write_head_tail got %0d %0d want 5 8", enq_head, enq_tail);
    end
    checks++; if (enq_bitmap !== 4'b0010 || enq_cnt !== 6'd4) begin
      errors++; $display("FAIL write_bitmap_cnt got %b %0d want 0010 4", enq_bitmap, enq_cnt);
    end
    ack_enq();
    checks++; if (enq_valid !== 1'b0) begin errors++; $display("FAIL write_enq_drop got %0b want 0", enq_valid); end
    checks++; if (sram_n - s0 != 16) begin errors++; $display("FAIL write_sram_count got %0d want 16", sram_n - s0); end
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (sram_a[s0+i] !== 12'(20 + i) || sram_d[s0+i] !== DATA_W'(i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL write_sram_addr_data got %0d bad want 0", bad); end
    checks++; if (link_n - l0 != 3) begin errors++; $display("FAIL write_link_count got %0d want 3", link_n - l0); end
    bad = 0;
    for (int i = 0; i < 3; i++)
      if (link_a[l0+i] !== 10'(5 + i) || link_d[l0+i] !== 10'(6 + i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL write_links got %0d bad want 0", bad); end
    checks++; if (fqrd_n - f0 != 4) begin errors++; $display("FAIL write_fq_rd got %0d want 4", fqrd_n - f0); end
  endtask

  task automatic test_drop;
    int s0, l0, f0, d0, got, bad;
    bit ok;
    s0 = sram_n; f0 = fqrd_n; d0 = drop_n;
    fq_count = 11'd3;
    push_desc(4'b0001, 6'd4);
    send_beats(16, 0, got);
    tick();
    checks++; if (got != 16) begin errors++; $display("FAIL drop_beats got %0d want 16", got); end
    checks++; if (data_bp !== 1'b1) begin errors++; $display("FAIL drop_idle_bp got %0b want 1", data_bp); end
    checks++; if (drop_n - d0 != 1) begin errors++; $display("FAIL drop_pulses got %0d want 1", drop_n - d0); end
    checks++; if (sram_n != s0 || fqrd_n != f0) begin
      errors++; $display("FAIL drop_no_writes got %0d %0d want 0 0", sram_n - s0, fqrd_n - f0);
    end
    fq_count = 11'd100;
    s0 = sram_n; l0 = link_n;
    set_start(40);
    push_desc(4'b0100, 6'd1);
    send_beats(4, 100, got);
    wait_enq(ok);
    checks++; if (!ok || enq_head !== 10'd40 || enq_tail !== 10'd40 || enq_bitmap !== 4'b0100) begin
      errors++; $display("FAIL drop_next_enq got v%0b %0d %0d %b want 1 40 40 0100", ok, enq_head, enq_tail, enq_bitmap);
    end
    ack_enq();
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (sram_a[s0+i] !== 12'(160 + i) || sram_d[s0+i] !== DATA_W'(100 + i)) bad++;
    checks++; if (sram_n - s0 != 4 || bad != 0) begin
      errors++; $display("FAIL drop_next_sram got n%0d bad%0d want n4 bad0", sram_n - s0, bad);
    end
    checks++; if (link_n != l0) begin errors++; $display("FAIL drop_next_links got %0d want 0", link_n - l0); end
  endtask

  task automatic test_zero;
    int s0, d0, nbp;
    s0 = sram_n; d0 = drop_n; nbp = 0;
    data_wr = 1'b1;
    data_in = '0;
    push_desc(4'b0001, 6'd0);
    for (int k = 0; k < 6; k++) begin
      if (!data_bp) nbp++;
      tick();
    end
    push_desc(4'b0000, 6'd3);
    for (int k = 0; k < 6; k++) begin
      if (!data_bp) nbp++;
      tick();
    end
    data_wr = 1'b0;
    checks++; if (nbp != 0) begin errors++; $display("FAIL zero_data_bp got %0d open cycles want 0", nbp); end
    checks++; if (drop_n - d0 != 2) begin errors++; $display("FAIL zero_drops got %0d want 2", drop_n - d0); end
    checks++; if (sram_n != s0) begin errors++; $display("FAIL zero_sram got %0d want 0", sram_n - s0); end
  endtask

  task automatic test_back_to_back;
    logic [NP-1:0] exp_bm [4];
    int got;
    bit ok;
    exp_bm[0] = 4'b0001; exp_bm[1] = 4'b0010;
    exp_bm[2] = 4'b0100; exp_bm[3] = 4'b1000;
    set_start(70);
    push_desc(4'b1111, 6'd1);
    repeat (3) tick();
    for (int k = 0; k < 4; k++) push_desc(exp_bm[k], 6'd1);
    checks++; if (desc_bp !== 1'b1) begin errors++; $display("FAIL b2b_full got %0b want 1", desc_bp); end
    push_desc(4'b0011, 6'd1);
    send_beats(4, 0, got);
    wait_enq(ok);
    checks++; if (!ok || enq_bitmap !== 4'b1111) begin
      errors++; $display("FAIL b2b_first got v%0b %b want 1 1111", ok, enq_bitmap);
    end
    ack_enq();
    for (int k = 0; k < 4; k++) begin
      send_beats(4, 0, got);
      wait_enq(ok);
      checks++; if (!ok || enq_bitmap !== exp_bm[k]) begin
        errors++; $display("FAIL b2b_order%0d got v%0b %b want 1 %b", k, ok, enq_bitmap, exp_bm[k]);
      end
      ack_enq();
    end
    repeat (5) tick();
    checks++; if (data_bp !== 1'b1 || enq_valid !== 1'b0 || desc_bp !== 1'b0) begin
      errors++; $display("FAIL b2b_fifth_lost got bp%0b v%0b dbp%0b want 1 0 0", data_bp, enq_valid, desc_bp);
    end
  endtask

  task automatic test_stall;
    int got;
    bit ok;
    set_start(90);
    push_desc(4'b1000, 6'd1);
    send_beats(4, 0, got);
    wait_enq(ok);
    data_wr = 1'b1;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (enq_valid !== 1'b1 || enq_head !== 10'd90 || enq_tail !== 10'd90 ||
          enq_bitmap !== 4'b1000 || enq_cnt !== 6'd1 || data_bp !== 1'b1) begin
        errors++;
        $display("FAIL stall_c%0d got v%0b %0d %0d %b %0d bp%0b want 1 90 90 1000 1 1",
                 k, enq_valid, enq_head, enq_tail, enq_bitmap, enq_cnt, data_bp);
      end
      tick();
    end
    data_wr = 1'b0;
    ack_enq();
    checks++; if (enq_valid !== 1'b0) begin errors++; $display("FAIL stall_release got %0b want 0", enq_valid); end
  endtask

  task automatic test_fq_empty;
    int s0, f0, got;
    s0 = sram_n; f0 = fqrd_n;
    fq_empty = 1'b1;
    push_desc(4'b0001, 6'd2);
    send_beats(8, 0, got);
    tick();
    fq_empty = 1'b0;
    checks++; if (got != 8) begin errors++; $display("FAIL fqe_beats got %0d want 8", got); end
    checks++; if (sram_n != s0 || fqrd_n != f0) begin
      errors++; $display("FAIL fqe_no_writes got %0d %0d want 0 0", sram_n - s0, fqrd_n - f0);
    end
    checks++; if (data_bp !== 1'b1 || enq_valid !== 1'b0) begin
      errors++; $display("FAIL fqe_idle got bp%0b v%0b want 1 0", data_bp, enq_valid);
    end
  endtask

  task automatic test_reset_mid;
    int s0, l0, got, bad;
    bit ok;
    set_start(50);
    push_desc(4'b0010, 6'd4);
    send_beats(6, 0, got);
    checks++; if (sram_wr !== 1'b1) begin errors++; $display("FAIL rmid_pre got %0b want 1", sram_wr); end
    rst = 1'b1;
    #1;
    checks++; if (sram_wr !== 1'b0 || data_bp !== 1'b1 || desc_bp !== 1'b0 ||
                  enq_valid !== 1'b0 || link_wr !== 1'b0 || fq_rd !== 1'b0) begin
      errors++; $display("FAIL rmid_async got wr%0b bp%0b dbp%0b v%0b want 0 1 0 0", sram_wr, data_bp, desc_bp, enq_valid);
    end
    tick();
    rst = 1'b0;
    tick();
    s0 = sram_n; l0 = link_n;
    set_start(60);
    push_desc(4'b1000, 6'd4);
    send_beats(16, 512, got);
    wait_enq(ok);
    checks++; if (!ok || enq_head !== 10'd60 || enq_tail !== 10'd63) begin
      errors++; $display("FAIL rmid_enq got v%0b %0d %0d want 1 60 63", ok, enq_head, enq_tail);
    end
    ack_enq();
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (sram_a[s0+i] !== 12'(240 + i) || sram_d[s0+i] !== DATA_W'(512 + i)) bad++;
    checks++; if (sram_n - s0 != 16 || bad != 0) begin
      errors++; $display("FAIL rmid_sram got n%0d bad%0d want n16 bad0", sram_n - s0, bad);
    end
    checks++; if (link_n - l0 != 3 || link_a[l0] !== 10'd60 || link_d[l0+2] !== 10'd63) begin
      errors++; $display("FAIL rmid_links got n%0d want 3", link_n - l0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    desc_din  = '0;
    desc_wr   = 1'b0;
    data_in   = '0;
    data_wr   = 1'b0;
    fq_empty  = 1'b0;
    fq_count  = 11'd100;
    enq_ready = 1'b0;
    test_reset();
    test_write();
    test_drop();
    test_zero();
    test_back_to_back();
    test_stall();
    test_fq_empty();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
